counter_ud_param: RTL

COUNTER_UD_PARAM -- requirements
Module: counter_ud_param

---
 rtl/counter_ud_pkg.sv | 18 +
 rtl/counter_ud_next.sv | 72 +++++++
 rtl/counter_ud_param.sv | 134 +++++++++++++
 3 files changed

// File: rtl/counter_ud_pkg.sv
// ----------------------------------------------------------------------------
// counter_ud_pkg
// Shared types and default constants for the up/down counter slice.
//   count_mode_t : CNT_WRAP (wrap modulo MAX_VAL+1) / CNT_SAT (saturate)
//   DEF_WIDTH    : default counter width
//   DEF_STEP_W   : default step input width
// ----------------------------------------------------------------------------
package counter_ud_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_STEP_W = 4;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } count_mode_t;

endpackage

// File: rtl/counter_ud_next.sv
// ----------------------------------------------------------------------------
// counter_ud_next
// Purely combinational next-count computation for counter_ud_param.
// Ports:
//   cnt      in  [WIDTH-1:0]  current registered count
//   inc/dec  in               up / down request (acts only when exactly one)
//   step     in  [STEP_W-1:0] magnitude, clamped to MAX_VAL
//   load     in               load strobe, highest priority
//   load_val in  [WIDTH-1:0]  load value, clamped to MAX_VAL
//   nxt_cnt  out [WIDTH-1:0]  count for the next clock
//   ovf_evt  out              this update crosses above MAX_VAL
//   unf_evt  out              this update crosses below 0
// ----------------------------------------------------------------------------
module counter_ud_next
    import counter_ud_pkg::*;
#(
    parameter int unsigned       WIDTH    = DEF_WIDTH,
    parameter int unsigned       STEP_W   = DEF_STEP_W,
    parameter logic [WIDTH-1:0]  MAX_VAL  = '1,
    parameter count_mode_t       SAT_MODE = CNT_WRAP
) (
    input  logic [WIDTH-1:0]  cnt,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  nxt_cnt,
    output logic              ovf_evt,
    output logic              unf_evt
);

    // One extra bit of headroom so cnt+step and cnt+MAX_VAL+1 never truncate.
    localparam logic [WIDTH:0] MAX_X = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] MOD_X = MAX_X + (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] eff_x;
    logic [WIDTH:0] sum_x;

    always_comb begin
        cnt_x   = {1'b0, cnt};
        step_x  = (WIDTH+1)'(step);
        eff_x   = (step_x > MAX_X) ? MAX_X : step_x;
        sum_x   = cnt_x + eff_x;
        nxt_cnt = cnt;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;

        if (load) begin
            nxt_cnt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if ((inc ^ dec) && (step != '0)) begin
            if (inc) begin
                if (sum_x > MAX_X) begin
                    ovf_evt = 1'b1;
                    nxt_cnt = (SAT_MODE == CNT_SAT) ? MAX_VAL : WIDTH'(sum_x - MOD_X);
                end else begin
                    nxt_cnt = WIDTH'(sum_x);
                end
            end else begin
                if (eff_x > cnt_x) begin
                    unf_evt = 1'b1;
                    nxt_cnt = (SAT_MODE == CNT_SAT) ? '0 : WIDTH'(cnt_x + MOD_X - eff_x);
                end else begin
                    nxt_cnt = WIDTH'(cnt_x - eff_x);
                end
            end
        end
    end

endmodule

// File: rtl/counter_ud_param.sv
// ----------------------------------------------------------------------------
// counter_ud_param
// Parameterised up/down counter with programmable step, bound, wrap or
// saturate behaviour and sticky overflow/underflow flags.
// Ports:
//   clk       in               rising-edge clock
//   rst_n     in               asynchronous active-low reset
//   inc/dec   in               up / down request
//   step      in  [STEP_W-1:0] step magnitude
//   load      in               synchronous load strobe
//   load_val  in  [WIDTH-1:0]  load value
//   clr_flags in               clear sticky ovf/unf (a same-cycle event wins)
//   cnt       out [WIDTH-1:0]  registered count, 0..MAX_VAL
//   ovf/unf   out              sticky overflow / underflow
//   at_max    out              cnt == MAX_VAL
//   at_min    out              cnt == 0
// Optional: define COUNTER_UD_SVA_EN to compile in assertions and covers.
// ----------------------------------------------------------------------------
module counter_ud_param
    import counter_ud_pkg::*;
#(
    parameter int unsigned       WIDTH    = DEF_WIDTH,
    parameter int unsigned       STEP_W   = DEF_STEP_W,
    parameter logic [WIDTH-1:0]  MAX_VAL  = '1,
    parameter count_mode_t       SAT_MODE = CNT_WRAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  cnt,
    output logic              ovf,
    output logic              unf,
    output logic              at_max,
    output logic              at_min
);

    logic [WIDTH-1:0] nxt_cnt;
    logic             ovf_evt;
    logic             unf_evt;

    counter_ud_next #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .MAX_VAL  (MAX_VAL),
        .SAT_MODE (SAT_MODE)
    ) u_next (
        .cnt      (cnt),
        .inc      (inc),
        .dec      (dec),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .nxt_cnt  (nxt_cnt),
        .ovf_evt  (ovf_evt),
        .unf_evt  (unf_evt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            cnt <= nxt_cnt;
            // Set event takes precedence over the clear strobe.
            ovf <= ovf_evt | (ovf & ~clr_flags);
            unf <= unf_evt | (unf & ~clr_flags);
        end
    end

    assign at_max = (cnt == MAX_VAL);
    assign at_min = (cnt == '0);

`ifdef COUNTER_UD_SVA_EN
    localparam logic [WIDTH:0] SVA_MAX_X = {1'b0, MAX_VAL};

    logic [WIDTH:0] sva_cnt_x;
    logic [WIDTH:0] sva_eff_x;
    logic           sva_cmd;

    always_comb begin
        sva_cnt_x = {1'b0, cnt};
        sva_eff_x = ((WIDTH+1)'(step) > SVA_MAX_X) ? SVA_MAX_X : (WIDTH+1)'(step);
        sva_cmd   = !load && (inc ^ dec) && (step != '0);
    end

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (!load && ((inc == dec) || (step == '0)))
        |=> (cnt == $past(cnt)) && !$rose(ovf) && !$rose(unf))
        else $error("counter_ud_param hold violated at %0t", $time);

    a_inc: assert property (@(posedge clk) disable iff (!rst_n)
        (sva_cmd && inc && ((sva_cnt_x + sva_eff_x) <= SVA_MAX_X))
        |=> (cnt == WIDTH'($past(sva_cnt_x + sva_eff_x))))
        else $error("counter_ud_param inc violated at %0t", $time);

    a_inc_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        (sva_cmd && inc && ((sva_cnt_x + sva_eff_x) > SVA_MAX_X))
        |=> ovf && (cnt == ((SAT_MODE == CNT_SAT) ? MAX_VAL
                    : WIDTH'($past(sva_cnt_x + sva_eff_x) - SVA_MAX_X - (WIDTH+1)'(1)))))
        else $error("counter_ud_param overflow violated at %0t", $time);

    a_dec: assert property (@(posedge clk) disable iff (!rst_n)
        (sva_cmd && dec && (sva_eff_x <= sva_cnt_x))
        |=> (cnt == WIDTH'($past(sva_cnt_x - sva_eff_x))))
        else $error("counter_ud_param dec violated at %0t", $time);

    a_dec_unf: assert property (@(posedge clk) disable iff (!rst_n)
        (sva_cmd && dec && (sva_eff_x > sva_cnt_x))
        |=> unf && (cnt == ((SAT_MODE == CNT_SAT) ? '0
                    : WIDTH'($past(sva_cnt_x + SVA_MAX_X + (WIDTH+1)'(1) - sva_eff_x)))))
        else $error("counter_ud_param underflow violated at %0t", $time);

    a_clr: assert property (@(posedge clk) disable iff (!rst_n)
        clr_flags |=> (ovf == $past(ovf_evt)) && (unf == $past(unf_evt)))
        else $error("counter_ud_param clr_flags violated at %0t", $time);

    a_range: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(cnt) && (cnt <= MAX_VAL))
        else $error("counter_ud_param range violated at %0t", $time);

    c_hold:    cover property (@(posedge clk) disable iff (!rst_n) !load && inc && dec);
    c_ovf:     cover property (@(posedge clk) disable iff (!rst_n) ovf_evt);
    c_unf:     cover property (@(posedge clk) disable iff (!rst_n) unf_evt);
    c_clr_win: cover property (@(posedge clk) disable iff (!rst_n) clr_flags && (ovf_evt || unf_evt));
    c_at_max:  cover property (@(posedge clk) disable iff (!rst_n) at_max);
`endif

endmodule
